wb_gain_corrector_mc: RTL and testbench

- Next-generation white balance gain stage with CHANNELS independent channels, each multiplied by a fixed-point gain, rounded and saturated.
- Gains are written into a shadow bank and committed frame-synchronously at start of frame (SOF, tuser=1), so no frame ever mixes gain sets.
- Adds bypass and a per-frame clipped-pixel count.
- Sits in the video pipeline after demosaic, fed by AWB estimators or software through a control block.

---
 rtl/wb_gain_pkg.sv | 22 ++
 rtl/axi4_stream_if.sv | 20 ++
 rtl/wb_gain_channel.sv | 57 +++++
 rtl/wb_gain_corrector_mc.sv | 150 +++++++++++++++
 tb/tb_wb_gain_corrector_mc.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_gain_pkg.sv
// Shared types and width helpers for the multi-channel white-balance gain stage.
// The commit FSM only distinguishes "no commit pending" from "commit armed for next SOF".
package wb_gain_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } commit_state_e;

  function automatic int coef_width(input int int_w, input int fract_w);
    return int_w + fract_w;
  endfunction

  function automatic int tdata_width(input int px_w, input int channels);
    return ((px_w * channels + 7) / 8) * 8;
  endfunction

  function automatic logic [31:0] fixed_one(input int fract_w);
    return 32'd1 << fract_w;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle used on both video ports; tstrb/tkeep are one bit per tdata byte.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1
) ();
  logic                     tvalid;
  logic                     tready;
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tstrb;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic                     tlast;
  logic [TUSER_WIDTH-1:0]   tuser;
  logic [TID_WIDTH-1:0]     tid;
  logic [TDEST_WIDTH-1:0]   tdest;

  modport master (output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest, input tready);
  modport slave  (input tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest, output tready);
endinterface

// File: rtl/wb_gain_channel.sv
// One channel: stage 1 registers sample*gain (or the raw sample in bypass), stage 2 rounds
// half-up and saturates to PX_WIDTH bits with a clip flag; each stage holds unless enabled.
module wb_gain_channel #(
  parameter int PX_WIDTH    = 10,
  parameter int COEF_WIDTH  = 14,
  parameter int FRACT_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  s1_en,
  input  logic                  s2_en,
  input  logic                  bypass,
  input  logic [PX_WIDTH-1:0]   sample,
  input  logic [COEF_WIDTH-1:0] gain,
  output logic [PX_WIDTH-1:0]   px,
  output logic                  clip
);
  localparam int PROD_W = PX_WIDTH + COEF_WIDTH;
  localparam int RND_W  = PROD_W + 1;
  localparam logic [RND_W-1:0] HALF   = RND_W'(1) << (FRACT_WIDTH - 1);
  localparam logic [RND_W-1:0] PX_MAX = RND_W'({PX_WIDTH{1'b1}});

  logic [PROD_W-1:0] prod_q;
  logic              byp_q;
  logic [RND_W-1:0]  rounded;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prod_q <= '0;
      byp_q  <= 1'b0;
    end else if (s1_en) begin
      byp_q  <= bypass;
      prod_q <= bypass ? PROD_W'(sample) : PROD_W'(sample) * PROD_W'(gain);
    end
  end

  // One spare bit so the rounding increment can never wrap.
  assign rounded = ({1'b0, prod_q} + HALF) >> FRACT_WIDTH;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      px   <= '0;
      clip <= 1'b0;
    end else if (s2_en) begin
      if (byp_q) begin
        px   <= prod_q[PX_WIDTH-1:0];
        clip <= 1'b0;
      end else if (rounded > PX_MAX) begin
        px   <= '1;
        clip <= 1'b1;
      end else begin
        px   <= rounded[PX_WIDTH-1:0];
        clip <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/wb_gain_corrector_mc.sv
// Multi-channel white-balance gain with frame-synchronous gain commit, bypass and per-frame
// clip count; 2-cycle latency, full rate, each stage holds its beat under video_o backpressure.
module wb_gain_corrector_mc
  import wb_gain_pkg::*;
#(
  parameter int  PX_WIDTH       = 10,
  parameter int  CHANNELS       = 3,
  parameter int  FRACT_WIDTH    = 10,
  parameter int  COEF_INT_WIDTH = 4,
  parameter int  CNT_WIDTH      = 24,
  localparam int COEF_WIDTH     = coef_width(COEF_INT_WIDTH, FRACT_WIDTH),
  localparam int SEL_WIDTH      = $clog2(CHANNELS)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  coef_wr_i,
  input  logic [SEL_WIDTH-1:0]  coef_sel_i,
  input  logic [COEF_WIDTH-1:0] coef_data_i,
  input  logic                  commit_i,
  input  logic                  bypass_i,
  output logic                  commit_pending_o,
  output logic                  commit_done_o,
  output logic [CNT_WIDTH-1:0]  sat_cnt_o,
  axi4_stream_if.slave          video_i,
  axi4_stream_if.master         video_o
);
  localparam int TDW = tdata_width(PX_WIDTH, CHANNELS);
  localparam int KW  = TDW / 8;
  localparam logic [COEF_WIDTH-1:0] GAIN_ONE = COEF_WIDTH'(fixed_one(FRACT_WIDTH));

  logic s1_vld, out_vld, s1_rdy, s2_rdy, in_acc, out_acc, sof_commit;
  logic s1_last, s1_user, s1_id, s1_dest, out_last, out_user, out_id, out_dest;
  logic [KW-1:0] s1_strb, s1_keep, out_strb, out_keep;
  logic [TDW-1:0] tdata_o;
  logic [PX_WIDTH-1:0] px_s [CHANNELS];
  logic [CHANNELS-1:0] clip_s;
  logic [COEF_WIDTH-1:0] shadow_q [CHANNELS];
  logic [COEF_WIDTH-1:0] active_q [CHANNELS];
  logic [CNT_WIDTH-1:0] acc_q, sat_q;
  logic done_q;
  commit_state_e state_q, state_d;

  assign s2_rdy     = video_o.tready || !out_vld;
  assign s1_rdy     = s2_rdy || !s1_vld;
  assign in_acc     = video_i.tvalid && s1_rdy;
  assign out_acc    = out_vld && video_o.tready;
  assign sof_commit = (state_q == ST_ARMED) && in_acc && video_i.tuser[0];

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    wb_gain_channel #(
      .PX_WIDTH   (PX_WIDTH),
      .COEF_WIDTH (COEF_WIDTH),
      .FRACT_WIDTH(FRACT_WIDTH)
    ) u_ch (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .s1_en  (in_acc),
      .s2_en  (s2_rdy && s1_vld),
      .bypass (bypass_i),
      .sample (video_i.tdata[PX_WIDTH*(k+1)-1 -: PX_WIDTH]),
      .gain   (sof_commit ? shadow_q[k] : active_q[k]),
      .px     (px_s[k]),
      .clip   (clip_s[k])
    );
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_vld  <= 1'b0;
      out_vld <= 1'b0;
      {s1_last, s1_user, s1_id, s1_dest, s1_strb, s1_keep} <= '0;
      {out_last, out_user, out_id, out_dest, out_strb, out_keep} <= '0;
    end else begin
      if (s1_rdy) s1_vld <= video_i.tvalid;
      if (in_acc) begin
        {s1_last, s1_user, s1_id, s1_dest} <=
          {video_i.tlast, video_i.tuser[0], video_i.tid[0], video_i.tdest[0]};
        {s1_strb, s1_keep} <= {video_i.tstrb, video_i.tkeep};
      end
      if (s2_rdy) out_vld <= s1_vld;
      if (s2_rdy && s1_vld) begin
        {out_last, out_user, out_id, out_dest, out_strb, out_keep} <=
          {s1_last, s1_user, s1_id, s1_dest, s1_strb, s1_keep};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (commit_i)   state_d = ST_ARMED;
      ST_ARMED: if (sof_commit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Active copies the pre-write shadow, so a same-cycle write waits for the next commit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < CHANNELS; k++) begin
        shadow_q[k] <= GAIN_ONE;
        active_q[k] <= GAIN_ONE;
      end
      done_q <= 1'b0;
    end else begin
      done_q <= sof_commit;
      for (int k = 0; k < CHANNELS; k++) begin
        if (sof_commit) active_q[k] <= shadow_q[k];
        if (coef_wr_i && coef_sel_i == SEL_WIDTH'(k)) shadow_q[k] <= coef_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q <= '0;
      sat_q <= '0;
    end else if (out_acc) begin
      if (out_user) begin
        sat_q <= acc_q;
        acc_q <= CNT_WIDTH'(|clip_s);
      end else if (|clip_s && acc_q != '1) begin
        acc_q <= acc_q + 1'b1;
      end
    end
  end

  always_comb begin
    tdata_o = '0;
    for (int k = 0; k < CHANNELS; k++) tdata_o[PX_WIDTH*k +: PX_WIDTH] = px_s[k];
  end

  assign video_i.tready   = s1_rdy;
  assign video_o.tvalid   = out_vld;
  assign video_o.tdata    = tdata_o;
  assign video_o.tlast    = out_last;
  assign video_o.tuser    = out_user;
  assign video_o.tid      = out_id;
  assign video_o.tdest    = out_dest;
  assign video_o.tstrb    = out_strb;
  assign video_o.tkeep    = out_keep;
  assign commit_pending_o = (state_q == ST_ARMED);
  assign commit_done_o    = done_q;
  assign sat_cnt_o        = sat_q;
endmodule

// File: tb/tb_wb_gain_corrector_mc.sv
// Bench for wb_gain_corrector_mc: scenario tasks drive beats and compare the output stream
// against a frame-level gain/commit model kept here.
module tb_wb_gain_corrector_mc;
  localparam int PX = 10, CH = 3, FR = 10, CW = 14, CNTW = 24, TDW = 32;
  localparam int PXMAX = 1023, ONE = 1024;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic            coef_wr_i, commit_i, bypass_i;
  logic [1:0]      coef_sel_i;
  logic [CW-1:0]   coef_data_i;
  logic            commit_pending_o, commit_done_o;
  logic [CNTW-1:0] sat_cnt_o;

  axi4_stream_if #(.TDATA_WIDTH(TDW)) vin ();
  axi4_stream_if #(.TDATA_WIDTH(TDW)) vout ();

  wb_gain_corrector_mc #(
    .PX_WIDTH(PX), .CHANNELS(CH), .FRACT_WIDTH(FR), .COEF_INT_WIDTH(4), .CNT_WIDTH(CNTW)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .coef_wr_i(coef_wr_i), .coef_sel_i(coef_sel_i),
    .coef_data_i(coef_data_i), .commit_i(commit_i), .bypass_i(bypass_i),
    .commit_pending_o(commit_pending_o), .commit_done_o(commit_done_o), .sat_cnt_o(sat_cnt_o),
    .video_i(vin), .video_o(vout)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [TDW-1:0] data;
    logic           user;
    logic           last;
    logic           id;
  } beat_t;

  beat_t exp_q[$], got_q[$];
  int checks = 0, errors = 0;
  int rdy_mode = 0;               // 0: always ready, 1: random 50%, 2: stalled
  int done_seen = 0, done_exp = 0;
  int m_shadow[CH], m_active[CH], m_frame_clip, m_exp_sat;
  bit m_armed;

  // Output sink: decides tready for the coming edge and records every handshaked beat.
  always @(negedge clk_i) begin
    if (rdy_mode == 0)      vout.tready = 1'b1;
    else if (rdy_mode == 1) vout.tready = 1'($urandom_range(0, 1));
    else                    vout.tready = 1'b0;
    if (rst_n_i && vout.tvalid && vout.tready)
      got_q.push_back({vout.tdata, vout.tuser[0], vout.tlast, vout.tid[0]});
    if (rst_n_i && commit_done_o) done_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_shadow[k] = ONE;
      m_active[k] = ONE;
    end
    m_armed = 0; m_frame_clip = 0; m_exp_sat = 0;
    exp_q.delete(); got_q.delete();
  endtask

  function automatic int apply_gain(input int s, input int g, input bit byp, output bit clipped);
    int r;
    clipped = 0;
    if (byp) return s;
    r = (s * g + (1 << (FR - 1))) >> FR;
    if (r > PXMAX) begin
      clipped = 1;
      return PXMAX;
    end
    return r;
  endfunction

  function automatic logic [TDW-1:0] px3(input int a, input int b, input int c);
    return {2'b00, 10'(c), 10'(b), 10'(a)};
  endfunction

  // One clock of stimulus; strobes last exactly one edge. Called at negedge+1.
  task automatic cycle(input bit vld, input logic [TDW-1:0] d, input bit user, input bit last,
                       input bit id, input bit byp, input bit commit, input bit wr,
                       input int sel, input int wdata, output bit acc);
    bit pre, sofc, any, c;
    beat_t b;
    vin.tvalid = vld; vin.tdata = d; vin.tuser = user; vin.tlast = last; vin.tid = id;
    bypass_i = byp; commit_i = commit; coef_wr_i = wr;
    coef_sel_i = 2'(sel); coef_data_i = CW'(wdata);
    acc  = vld && vin.tready;
    pre  = m_armed;
    sofc = acc && pre && user;
    if (acc) begin
      b = '0; any = 0;
      for (int k = 0; k < CH; k++) begin
        b.data[PX*k +: PX] = PX'(apply_gain(int'(d[PX*k +: PX]),
                                            sofc ? m_shadow[k] : m_active[k], byp, c));
        any |= c;
      end
      b.user = user; b.last = last; b.id = id;
      exp_q.push_back(b);
      if (user) begin
        m_exp_sat = m_frame_clip;
        m_frame_clip = int'(any);
      end else m_frame_clip += int'(any);
    end
    if (sofc) begin
      for (int k = 0; k < CH; k++) m_active[k] = m_shadow[k];
      m_armed = 0;
      done_exp++;
    end else if (!pre && commit) m_armed = 1;
    if (wr && sel < CH) m_shadow[sel] = wdata;
    @(posedge clk_i); #1;
    vin.tvalid = 0; commit_i = 0; coef_wr_i = 0; bypass_i = 0;
    @(negedge clk_i); #1;
  endtask

  task automatic send(input logic [TDW-1:0] d, input bit user, input bit last, input bit id,
                      input bit byp, input bit commit, input bit wr, input int sel, input int wdata);
    bit acc;
    int n = 0;
    cycle(1, d, user, last, id, byp, commit, wr, sel, wdata, acc);
    while (!acc && n < 500) begin
      cycle(1, d, user, last, id, byp, 0, 0, 0, 0, acc);
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: beat not accepted, required acceptance within 500 cycles");
    end
  endtask

  task automatic idle(input bit commit, input bit wr, input int sel, input int wdata);
    bit acc;
    cycle(0, '0, 0, 0, 0, 0, commit, wr, sel, wdata, acc);
  endtask

  task automatic drain();
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 5000) begin
      @(negedge clk_i); #1;
      n++;
    end
    repeat (3) begin @(negedge clk_i); #1; end
    if (n >= 5000) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d beats, required %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    logic [TDW-1:0] d;
    #2;
    checks++; if (vout.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b, expected 0", vout.tvalid); end
    checks++; if (vout.tdata !== '0) begin errors++; $display("FAIL rst_tdata: got %h, expected 0", vout.tdata); end
    checks++; if (commit_pending_o !== 1'b0) begin errors++; $display("FAIL rst_pending: got %b, expected 0", commit_pending_o); end
    checks++; if (commit_done_o !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, expected 0", commit_done_o); end
    checks++; if (sat_cnt_o !== '0) begin errors++; $display("FAIL rst_sat: got %0d, expected 0", sat_cnt_o); end
    @(negedge clk_i); rst_n_i = 1'b1; #1;
    model_reset();
    d = px3(100, 100, 100);
    send(d, 1, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (vout.tvalid !== 1'b0) begin errors++; $display("FAIL lat1_tvalid: got %b, expected 0", vout.tvalid); end
    @(negedge clk_i); #1;
    checks++; if (vout.tvalid !== 1'b1 || vout.tdata !== d) begin
      errors++; $display("FAIL lat2_out: got vld %b data %h, expected 1 %h", vout.tvalid, vout.tdata, d);
    end
    drain();
    checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin errors++; $display("FAIL unity_beat: got %0d beats, expected 1 matching model", got_q.size()); end
    checks++; if (sat_cnt_o !== '0) begin errors++; $display("FAIL unity_sat: got %0d, expected 0", sat_cnt_o); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_gain_commit();
    int d0 = done_seen;
    idle(0, 1, 0, 1536);
    idle(1, 0, 0, 0);
    checks++; if (commit_pending_o !== 1'b1) begin errors++; $display("FAIL gc_pending: got %b, expected 1", commit_pending_o); end
    send(px3(100, 200, 300), 1, 0, 0, 0, 0, 0, 0, 0);
    send(px3(700, 10, 20), 0, 0, 1, 0, 0, 0, 0, 0);
    send(px3(700, 0, 0), 0, 1, 0, 0, 0, 0, 0, 0);
    idle(0, 1, 0, 512);
    idle(1, 0, 0, 0);
    send(px3(3, 5, 7), 1, 1, 0, 0, 0, 0, 0, 0);
    drain();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL gc_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL gc_beat[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() == 4) begin
      checks++; if (got_q[0].data !== px3(150, 200, 300)) begin errors++; $display("FAIL gc_x1p5: got %h, expected %h", got_q[0].data, px3(150, 200, 300)); end
      checks++; if (got_q[1].data !== px3(1023, 10, 20)) begin errors++; $display("FAIL gc_clip: got %h, expected %h", got_q[1].data, px3(1023, 10, 20)); end
      checks++; if (got_q[3].data !== px3(2, 5, 7)) begin errors++; $display("FAIL gc_round: got %h, expected %h", got_q[3].data, px3(2, 5, 7)); end
    end
    checks++; if (sat_cnt_o !== 24'd2) begin errors++; $display("FAIL gc_sat: got %0d, expected 2", sat_cnt_o); end
    checks++; if (done_seen - d0 != 2) begin errors++; $display("FAIL gc_done: got %0d pulses, expected 2", done_seen - d0); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_midframe_commit();
    int d0 = done_seen;
    send(px3(50, 60, 70), 1, 0, 0, 0, 0, 0, 0, 0);
    send($urandom, 0, 0, 1, 0, 0, 0, 0, 0);
    send($urandom, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 1, 1, 2048);
    idle(1, 0, 0, 0);
    idle(1, 0, 0, 0);
    checks++; if (commit_pending_o !== 1'b1) begin errors++; $display("FAIL mf_armed: got %b, expected 1", commit_pending_o); end
    send(px3(400, 400, 400), 0, 0, 0, 0, 0, 0, 0, 0);
    send(px3(100, 100, 100), 0, 1, 0, 0, 0, 0, 0, 0);
    send(px3(8, 100, 9), 1, 0, 1, 0, 0, 1, 1, 3072);
    checks++; if (commit_pending_o !== 1'b0) begin errors++; $display("FAIL mf_applied: got %b, expected 0", commit_pending_o); end
    send($urandom, 0, 1, 0, 0, 0, 0, 0, 0);
    send(px3(8, 100, 9), 1, 0, 0, 0, 1, 0, 0, 0);
    checks++; if (commit_pending_o !== 1'b1) begin errors++; $display("FAIL mf_rearm: got %b, expected 1", commit_pending_o); end
    send($urandom, 0, 1, 1, 0, 0, 0, 0, 0);
    send(px3(8, 100, 9), 1, 1, 0, 0, 0, 0, 0, 0);
    drain();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL mf_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mf_beat[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() == 10) begin
      checks++; if (got_q[3].data !== px3(200, 400, 400)) begin errors++; $display("FAIL mf_oldgain: got %h, expected %h", got_q[3].data, px3(200, 400, 400)); end
      checks++; if (got_q[5].data !== px3(4, 200, 9)) begin errors++; $display("FAIL mf_sofgain: got %h, expected %h", got_q[5].data, px3(4, 200, 9)); end
      checks++; if (got_q[7].data !== px3(4, 200, 9)) begin errors++; $display("FAIL mf_samecyc: got %h, expected %h", got_q[7].data, px3(4, 200, 9)); end
      checks++; if (got_q[9].data !== px3(4, 300, 9)) begin errors++; $display("FAIL mf_latewr: got %h, expected %h", got_q[9].data, px3(4, 300, 9)); end
    end
    checks++; if (done_seen - d0 != 2 || done_seen != done_exp) begin errors++; $display("FAIL mf_done: got %0d pulses, expected 2", done_seen - d0); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random_backpressure();
    rdy_mode = 1;
    for (int k = 0; k < CH; k++) idle(0, 1, k, int'($urandom_range(0, 4095)));
    idle(0, 1, 3, 1);
    idle(1, 0, 0, 0);
    for (int i = 0; i < 1000; i++)
      send($urandom, i == 0, i == 999, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, 0, 0, 0, 0);
    send($urandom, 1, 1, 0, 0, 0, 0, 0, 0);
    drain();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (sat_cnt_o !== CNTW'(m_exp_sat)) begin errors++; $display("FAIL bp_sat: got %0d, expected %0d", sat_cnt_o, m_exp_sat); end
    rdy_mode = 0;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_bypass();
    for (int k = 0; k < CH; k++) idle(0, 1, k, 2048);
    idle(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) send($urandom, i == 0, i == 39, 0, i % 2 == 1, 0, 0, 0, 0);
    send($urandom, 1, 1, 0, 0, 0, 0, 0, 0);
    drain();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL byp_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL byp_beat[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (sat_cnt_o !== CNTW'(m_exp_sat)) begin errors++; $display("FAIL byp_sat: got %0d, expected %0d", sat_cnt_o, m_exp_sat); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_midframe();
    logic [TDW-1:0] d;
    int d0;
    rdy_mode = 2;
    for (int k = 0; k < CH; k++) idle(0, 1, k, 3072);
    idle(1, 0, 0, 0);
    send($urandom, 0, 0, 0, 0, 0, 0, 0, 0);
    send($urandom, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (vout.tvalid !== 1'b1 || commit_pending_o !== 1'b1) begin
      errors++; $display("FAIL rm_pre: got vld %b pending %b, expected 1 1", vout.tvalid, commit_pending_o);
    end
    #2 rst_n_i = 1'b0;
    #1;
    checks++; if (vout.tvalid !== 1'b0) begin errors++; $display("FAIL rm_tvalid: got %b, expected 0", vout.tvalid); end
    checks++; if (commit_pending_o !== 1'b0) begin errors++; $display("FAIL rm_pending: got %b, expected 0", commit_pending_o); end
    model_reset();
    rdy_mode = 0;
    @(negedge clk_i); rst_n_i = 1'b1; #1;
    @(negedge clk_i); #1;
    d0 = done_seen;
    d = $urandom;
    send(d, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) send($urandom, 0, i == 4, 1, 0, 0, 0, 0, 0);
    send($urandom, 1, 1, 0, 0, 0, 0, 0, 0);
    drain();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rm_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rm_beat[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0].data !== (d & 32'h3FFF_FFFF)) begin errors++; $display("FAIL rm_unity: got %h, expected %h", got_q[0].data, d & 32'h3FFF_FFFF); end
    end
    checks++; if (done_seen != d0) begin errors++; $display("FAIL rm_done: got %0d pulses, expected 0", done_seen - d0); end
    checks++; if (sat_cnt_o !== '0) begin errors++; $display("FAIL rm_sat: got %0d, expected 0", sat_cnt_o); end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    rst_n_i = 1'b0;
    vin.tvalid = 0; vin.tdata = '0; vin.tuser = '0; vin.tlast = 0; vin.tid = '0; vin.tdest = '0;
    vin.tstrb = '1; vin.tkeep = '1;
    coef_wr_i = 0; coef_sel_i = '0; coef_data_i = '0; commit_i = 0; bypass_i = 0;
    model_reset();
    test_reset();
    test_gain_commit();
    test_midframe_commit();
    test_random_backpressure();
    test_bypass();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
